// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Counting core of the timer IP. This block keeps the 64-bit free-running
// counter that the register block reads back through TDR0/TDR1. It also
// provides an optional power-of-two prescaler, TDR write-back of either half,
// and a debug-halt freeze with an acknowledge.
//
// Ports
//   sys_clk      in   1   single clock
//   sys_rst_n    in   1   asynchronous active-low reset
//   timer_en     in   1   counting enable; its falling edge clears cnt
//   div_en       in   1   prescaler enable
//   div_val      in   4   prescaler exponent, 0..DIV_MAX
//   halt_req     in   1   debug halt request
//   dbg_mode     in   1   system debug mode; a halt is honoured only while high
//   tdr0_wr_sel  in   1   write strobe for cnt[31:0]
//   tdr1_wr_sel  in   1   write strobe for cnt[63:32]
//   tim_wdata    in  32   data for the TDR strobes
//   cnt          out 64   registered counter value
//   halt_ack     out  1   registered halt acknowledge
//
// Configuration macro
//   TIMER_HALT_EN  defined   : halt_req & dbg_mode freeze counting, halt_ack follows
//                  undefined : halt inputs ignored, halt_ack tied low
// ---------------------------------------------------------------------------
module timer_counter #(
  parameter int CNT_W   = 64,
  parameter int DIV_MAX = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             halt_req,
  input  logic             dbg_mode,
  input  logic             tdr0_wr_sel,
  input  logic             tdr1_wr_sel,
  input  logic [31:0]      tim_wdata,
  output logic [CNT_W-1:0] cnt,
  output logic             halt_ack
);

  // The divider must reach 2^DIV_MAX - 1, which needs DIV_MAX bits.
  localparam int DIV_CNT_W = DIV_MAX;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]           div_val_q, div_val_d;
  logic                 timer_en_q, timer_en_d;
  logic                 halt_ack_q, halt_ack_d;

  logic                 halted_s;
  logic                 tick_s;
  logic                 en_fall_s;
  logic [DIV_CNT_W-1:0] div_term_s;

`ifdef TIMER_HALT_EN
  assign halted_s = halt_req & dbg_mode;
`else
  logic halt_unused_s;
  assign halt_unused_s = halt_req ^ dbg_mode;
  assign halted_s      = 1'b0;
`endif

  // Terminal divider count 2^div_val - 1. For div_val == DIV_MAX the shifted
  // one falls off the top and the subtraction wraps to all ones, which is
  // exactly the wanted terminal value.
  assign div_term_s = (DIV_CNT_W'(1'b1) << div_val) - DIV_CNT_W'(1'b1);

  assign en_fall_s = timer_en_q & ~timer_en;

  // Prescaler counter next state: restart phase on disable or exponent change.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!timer_en || !div_en || (div_val != div_val_q)) begin
      div_cnt_d = {DIV_CNT_W{1'b0}};
    end else if (!halted_s) begin
      if (div_cnt_q == div_term_s) begin
        div_cnt_d = {DIV_CNT_W{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + DIV_CNT_W'(1'b1);
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Count-enable pulse; the halt gate is combinational so no increment slips.
  always_comb begin
    tick_s = 1'b0;
    if (!div_en || (div_val == 4'd0)) begin
      tick_s = timer_en & ~halted_s;
    end else begin
      tick_s = timer_en & ~halted_s & (div_cnt_q == div_term_s);
    end
  end

  // Counter next state: TDR write > enable falling edge > tick > hold.
  always_comb begin
    cnt_d = cnt_q;
    if (tdr0_wr_sel || tdr1_wr_sel) begin
      // A write always wins, so a coinciding tick is dropped.
      if (tdr0_wr_sel) begin
        cnt_d[31:0] = tim_wdata;
      end else begin
        cnt_d[31:0] = cnt_q[31:0];
      end
      if (tdr1_wr_sel) begin
        cnt_d[CNT_W-1:32] = tim_wdata;
      end else begin
        cnt_d[CNT_W-1:32] = cnt_q[CNT_W-1:32];
      end
    end else if (en_fall_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shadow copies used for edge / change detection and the halt handshake.
  always_comb begin
    timer_en_d = timer_en;
    div_val_d  = div_val;
    halt_ack_d = halted_s;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= {CNT_W{1'b0}};
      div_cnt_q  <= {DIV_CNT_W{1'b0}};
      div_val_q  <= 4'h1;
      timer_en_q <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_val_q  <= div_val_d;
      timer_en_q <= timer_en_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign cnt      = cnt_q;
  assign halt_ack = halt_ack_q;

endmodule

// File: doc/timer_counter.md
# timer_counter

Counting core of the timer IP. Sits directly downstream of the timer register block and consumes its control outputs: `timer_en`, `div_en`, `div_val`, `halt_req`, `tdr0_wr_sel` and `tdr1_wr_sel`. It produces the 64-bit `cnt` value that the register block reads back through TDR0/TDR1 and compares against TCMP0/TCMP1. It also returns `halt_ack` for the THCSR register.

## Interface
Parameters:
- `CNT_W`, 64: counter width; fixed at 64, split into two 32-bit halves for TDR0/TDR1.
- `DIV_MAX`, 8: largest legal `div_val`; the register block never passes a larger value.

Ports:
- `sys_clk`  in  1: single clock.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `timer_en`  in  1: counting enable (TCR[0]).
- `div_en`  in  1: prescaler enable (TCR[1]).
- `div_val`  in  4: prescaler exponent (TCR[11:8]), range 0..8.
- `halt_req`  in  1: debug halt request (THCSR[0]).
- `dbg_mode`  in  1: debug mode from the system; a halt is honoured only while this is high.
- `tdr0_wr_sel`  in  1: write strobe for cnt[31:0].
- `tdr1_wr_sel`  in  1: write strobe for cnt[63:32].
- `tim_wdata`  in  32: write data that accompanies the TDR strobes.
- `cnt`  out  64: registered counter value.
- `halt_ack`  out  1: registered halt acknowledge.

## Operation
- `halted` = `halt_req` & `dbg_mode`, evaluated combinationally.
- Divider:
  - `div_cnt` is an 8-bit register.
  - `div_cnt` clears to 0 whenever `timer_en`=0 or `div_en`=0, or on any cycle where `div_val` differs from its registered copy `div_val_q`.
  - Otherwise, when not halted, `div_cnt` increments and wraps to 0 once it equals (2^`div_val`)−1.
- Tick:
  - When `div_en`=0 or `div_val`=0: `tick` = `timer_en` & ~`halted`.
  - Otherwise: `tick` = `timer_en` & ~`halted` & (`div_cnt` == (2^`div_val`)−1).
  - With prescaling, `cnt` advances once every 2^`div_val` enabled cycles.
- Counter update priority, applied per cycle, highest first:
  1. `tdr0_wr_sel` loads cnt[31:0] from `tim_wdata`; `tdr1_wr_sel` loads cnt[63:32] from `tim_wdata`. The unwritten half holds.
  2. A `timer_en` falling edge, detected against registered `timer_en_q`, clears `cnt` to 0.
  3. `tick` increments `cnt` by 1 modulo 2^64.
  4. Otherwise `cnt` holds.
- A TDR write on the same cycle as a tick wins: the written half takes the write data and the tick is lost.
- Both strobes asserted in one cycle load both halves from the same `tim_wdata` (not generated by the register block; defined for robustness).
- Halt:
  - While `halted`, `cnt` and `div_cnt` freeze; TDR writes are still honoured.
  - On release, counting resumes from the frozen `div_cnt`, with no phase reset.
- Reset values: `cnt`=0, `halt_ack`=0, `div_cnt`=0, `timer_en_q`=0, `div_val_q`=4'h1.
- An asynchronous reset asserted mid-count forces all of the above immediately.

## Timing
- `cnt` changes on the `sys_clk` rising edge that ends the cycle in which `tick` or a write strobe is high. A TDR write is visible on `cnt` one cycle after the strobe.
- First increment after `timer_en` rises, with `div_en`=0: `cnt` reads 1 one cycle after `timer_en` is first sampled high.
- With `div_val`=N>0: the first increment occurs 2^N cycles after `timer_en` is first sampled high, and every 2^N cycles after that.
- Halt handshake:
  - `halt_ack` rises one cycle after `halted` rises and falls one cycle after `halted` falls.
  - The freeze itself takes effect in the same cycle `halted` is high, so no increment slips past a halt request.
- Wrap-around: from 64'hFFFF_FFFF_FFFF_FFFF, the next tick yields 0, with no flag raised. Match detection is the register block's job.

## Configuration
- Macro `TIMER_HALT_EN`.
- Defined: halt logic as described above.
- Undefined: `halt_req` and `dbg_mode` are ignored, `halted` is constant 0, and `halt_ack` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then `timer_en`=1, `div_en`=0 for 10 cycles -> `cnt` reads 10; no increments before `timer_en` is sampled.
- `div_en`=1, `div_val`=3, `timer_en`=1 for 32 cycles -> `cnt`=4. Change `div_val` to 1 mid-period -> `div_cnt` clears and the next increment arrives 2 cycles later.
- Write TDR0=32'hFFFF_FFFF, TDR1=32'hFFFF_FFFF with the timer enabled -> `cnt` reads 64'hFFFF_FFFF_FFFF_FFFF, then 0 on the next tick. A TDR0 write coinciding with a tick -> `cnt[31:0]` equals the written value exactly.
- `dbg_mode`=1 with `halt_req` raised while counting at `cnt`=5 -> `cnt` holds at 5 and `halt_ack`=1 one cycle later. Drop `halt_req` -> `halt_ack`=0 next cycle and counting resumes at 6.
- `halt_req`=1 with `dbg_mode`=0 -> no freeze and `halt_ack` stays 0. Rebuild without `TIMER_HALT_EN` and raise both -> no freeze and `halt_ack` stays 0.
- `timer_en` 1->0 at `cnt`=20 -> `cnt`=0 next cycle. Assert `sys_rst_n` low mid-count -> `cnt`=0 and `halt_ack`=0 immediately, before the next clock edge.
